membrane_store: RTL and testbench
=================================

// Module: membrane_store
// PURPOSE
//  Memory-side endpoint for partial_sum adder output packets. Each adder writes back its updated
//  membrane potentials and spike addresses, and the last adder sends a row-done marker.
//  At the end of each timestep the block publishes the spike map, then streams every stored
//  membrane potential back to the adders, which consume them in the next timestep.
//  It sits between the adder output mesh port and the adder input mesh port.
// PARAMETERS
//  WIDTH            64       packet width
//  WIDTH_MP         13       membrane potential width
//  ADDER_COUNT      5        number of adders; adder index a = 0..ADDER_COUNT-1
//  ROWS             5        output rows per adder per timestep
//  ADDER_ADDR_BASE  4'b0110  mesh address of adder 0; adder a sits at BASE+a
//  MEM_ADDR         4'b0000  this block's mesh address
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      adder packet valid
//  in_ready   out  1      block can accept a packet
//  in_data    in   WIDTH  {src[63:60], dst[59:56], type[55:54], zero, payload}
//  out_valid  out  1      replay packet valid
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  {MEM_ADDR, BASE+a, 2'b10, zero, mp[WIDTH_MP-1:0]}
//  spike_map  out  ROWS*ADDER_COUNT  spikes of the last completed timestep; bit r*ADDER_COUNT+a
//  ts_done    out  1      1-cycle pulse when a timestep closes
//  ts_count   out  8      completed-timestep count; wraps at 255 -> 0
//  err_pkt    out  1      1-cycle pulse on a malformed or dropped packet
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): outputs, FSM and registers are cleared.
//   in_ready=0, out_valid=0, spike_map=0, ts_done=0, ts_count=0, err_pkt=0.
//   Cleared state: mp regfile, pending spike bits, row_cnt[a], done_cnt, replay index, FSM=COLLECT.
//   in_ready goes to 1 in the first cycle after reset release.
//   Reset during REPLAY abandons the stream: out_valid=0 on the next cycle.
//  Transfers: a transfer occurs on valid&&ready at a clk edge.
//   out_data is held stable while out_valid && !out_ready.
//  FSM COLLECT (in_ready=1, out_valid=0): one packet decoded per accepted transfer.
//   idx = src - ADDER_ADDR_BASE.
//   If dst != MEM_ADDR, idx >= ADDER_COUNT, or type is not 2'b10/2'b11: drop the packet, pulse err_pkt.
//   type 2'b10: mp[row_cnt[idx]][idx] <= payload[WIDTH_MP-1:0]; row_cnt[idx]++, wraps ROWS-1 -> 0.
//   type 2'b11, payload[5:0]==6'h0F: row-done marker; done_cnt++.
//   type 2'b11, other payload: spike with r=payload[5:3], a=payload[2:0].
//    r >= ROWS or a >= ADDER_COUNT: drop the packet, pulse err_pkt.
//    Otherwise set pending[r*ADDER_COUNT+a].
//   Accepting the done marker that makes done_cnt==ROWS, next cycle:
//    spike_map <= pending; pending <= 0; ts_done=1; ts_count++; done_cnt <= 0; FSM -> REPLAY.
//    If any row_cnt != 0 at that point, also pulse err_pkt (incomplete timestep); replay proceeds anyway.
//  FSM REPLAY (in_ready=0): emits ROWS*ADDER_COUNT packets in row-major order.
//   Order: r=0..ROWS-1, then a=0..ADDER_COUNT-1 within each row.
//   First packet: out_valid=1 in the cycle after ts_done.
//   Each accepted packet advances the index.
//   Throughput: 1 packet/cycle when out_ready stays high.
//   After the last transfer: out_valid=0; FSM -> COLLECT on the next edge.
//  Arithmetic: mp values are stored and replayed unmodified (no saturation or sign handling).
//   Payload bits above WIDTH_MP are ignored.
//  Boundary: a spike for a neuron already set in pending stays set (idempotent).
//   A spike may arrive before or after its membrane packet; both orders are legal.
// STRUCTURE
//  snn_pkg: packet field localparams (SRC/DST/TYPE bit ranges), TYPE_MP=2'b10, TYPE_SPIKE=2'b11,
//   DONE_CODE=6'h0F, pkt_t struct, adder_idx_t.
//   The partial_sum conversion shares this package.
//  Sub-module membrane_regfile: ROWS x ADDER_COUNT x WIDTH_MP flops.
//   1 write port, 1 combinational read port, synchronous clear.
//  Top level: decoder, row/done counters, 2-state FSM, replay counter.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles -> in_ready=0, out_valid=0, spike_map=0, ts_count=0;
//    in_ready=1 one cycle after release.
//  2 Full timestep, defaults:
//    stimulus: 25 membrane packets (mp=r*10+a), spikes (r1,a2) and (r4,a0), 5 done markers.
//    response: ts_done pulse; spike_map=25'h0100080 (bits 7 and 20); ts_count=1;
//    25 replay packets in row-major order, e.g. 3rd = {0,8,2,...,13'd2}.
//  3 Backpressure: out_ready toggles 1/0 each cycle during replay ->
//    no packet lost or duplicated; out_data stable while stalled; replay lasts 50 cycles.
//  4 Bad packets, each -> err_pkt pulse and no state change:
//    src=4'b1111; dst=4'b0011; spike payload {3'd5,3'd1}; type 2'b01.
//  5 Incomplete timestep: 5 done markers with adder 3 missing one membrane packet ->
//    err_pkt and ts_done in the same cycle; replay still emits 25 packets.
//  6 Reset at the 7th replay packet -> out_valid=0 next cycle; FSM in COLLECT;
//    the next timestep replays all-zero mp for unwritten entries.

Source files
------------

// File: rtl/snn_pkg.sv
// Packet layout and field codes shared by the partial_sum adders and the membrane store.
// Packets are {src[63:60], dst[59:56], type[55:54], payload[53:0]}.
package snn_pkg;

    localparam int PKT_W     = 64;
    localparam int SRC_HI    = 63;
    localparam int SRC_LO    = 60;
    localparam int DST_HI    = 59;
    localparam int DST_LO    = 56;
    localparam int TYPE_HI   = 55;
    localparam int TYPE_LO   = 54;
    localparam int PAYLOAD_W = 54;

    localparam logic [1:0] TYPE_MP    = 2'b10;
    localparam logic [1:0] TYPE_SPIKE = 2'b11;
    localparam logic [5:0] DONE_CODE  = 6'h0F;

    typedef logic [3:0] adder_idx_t;

    typedef struct packed {
        logic [3:0]           src;
        logic [3:0]           dst;
        logic [1:0]           typ;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    // Adder index relative to the mesh address of adder 0; wraps modulo 16.
    function automatic adder_idx_t adder_index(input logic [3:0] src, input logic [3:0] base);
        return src - base;
    endfunction

endpackage

// File: rtl/membrane_regfile.sv
// ROWS x COLS array of membrane potentials: one write port, one combinational
// read port and a synchronous clear of the whole array.
module membrane_regfile #(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int WIDTH_MP = 13,
    parameter int RW       = 3,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [RW-1:0]       wr_row_i,
    input  logic [AW-1:0]       wr_col_i,
    input  logic [WIDTH_MP-1:0] wr_data_i,
    input  logic [RW-1:0]       rd_row_i,
    input  logic [AW-1:0]       rd_col_i,
    output logic [WIDTH_MP-1:0] rd_data_o
);

    logic [ROWS-1:0][COLS-1:0][WIDTH_MP-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/membrane_store.sv
// Memory-side endpoint for adder packets: collects membrane potentials and spikes
// for one timestep, publishes the spike map, then replays every potential back.
module membrane_store
    import snn_pkg::*;
#(
    parameter int         WIDTH           = 64,
    parameter int         WIDTH_MP        = 13,
    parameter int         ADDER_COUNT     = 5,
    parameter int         ROWS            = 5,
    parameter logic [3:0] ADDER_ADDR_BASE = 4'b0110,
    parameter logic [3:0] MEM_ADDR        = 4'b0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [ROWS*ADDER_COUNT-1:0] spike_map,
    output logic                        ts_done,
    output logic [7:0]                  ts_count,
    output logic                        err_pkt
);

    localparam int NEUR  = ROWS * ADDER_COUNT;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW    = (ADDER_COUNT > 1) ? $clog2(ADDER_COUNT) : 1;
    localparam int NW    = (NEUR > 1) ? $clog2(NEUR) : 1;
    localparam int PAD_W = WIDTH - 10 - WIDTH_MP;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_REPLAY  = 1'b1;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(ADDER_COUNT - 1);

    logic [0:0]                     state_q, state_d;
    logic                           live_q;
    logic [ADDER_COUNT-1:0][RW-1:0] row_cnt_q, row_cnt_d;
    logic [RW-1:0]                  done_cnt_q, done_cnt_d;
    logic [NEUR-1:0]                pending_q, pending_d;
    logic [NEUR-1:0]                spike_map_q, spike_map_d;
    logic                           ts_done_q, ts_done_d;
    logic [7:0]                     ts_count_q, ts_count_d;
    logic                           err_q, err_d;
    logic [RW-1:0]                  rep_row_q, rep_row_d;
    logic [AW-1:0]                  rep_col_q, rep_col_d;

    pkt_t                            pkt;
    adder_idx_t                      idx;
    logic [AW-1:0]                   col;
    logic [2:0]                      spk_r, spk_a;
    logic [NW-1:0]                   spk_bit;
    logic                            hdr_ok, spk_ok, is_mp, is_done;
    logic                            accept, out_fire, wr_en;
    logic [WIDTH_MP-1:0]             rd_mp;
    logic [PAYLOAD_W-WIDTH_MP-1:0]   payload_unused;

    assign pkt            = pkt_t'(in_data);
    assign idx            = adder_index(pkt.src, ADDER_ADDR_BASE);
    assign col            = idx[AW-1:0];
    assign spk_r          = pkt.payload[5:3];
    assign spk_a          = pkt.payload[2:0];
    assign spk_bit        = NW'(int'(spk_r) * ADDER_COUNT + int'(spk_a));
    assign payload_unused = pkt.payload[PAYLOAD_W-1:WIDTH_MP];

    assign hdr_ok  = (pkt.dst == MEM_ADDR) && (int'(idx) < ADDER_COUNT)
                     && ((pkt.typ == TYPE_MP) || (pkt.typ == TYPE_SPIKE));
    assign is_mp   = (pkt.typ == TYPE_MP);
    assign is_done = (pkt.typ == TYPE_SPIKE) && (pkt.payload[5:0] == DONE_CODE);
    assign spk_ok  = (int'(spk_r) < ROWS) && (int'(spk_a) < ADDER_COUNT);

    // The ts_done cycle is a one-cycle gap before the first replay packet.
    assign in_ready  = live_q && (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_REPLAY) && !ts_done_q;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_en     = accept && hdr_ok && is_mp;

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        done_cnt_d  = done_cnt_q;
        pending_d   = pending_q;
        spike_map_d = spike_map_q;
        ts_done_d   = 1'b0;
        ts_count_d  = ts_count_q;
        err_d       = 1'b0;
        rep_row_d   = rep_row_q;
        rep_col_d   = rep_col_q;

        if (accept) begin
            if (!hdr_ok) begin
                err_d = 1'b1;
            end else if (is_mp) begin
                row_cnt_d[col] = (row_cnt_q[col] == ROW_LAST) ? '0 : row_cnt_q[col] + 1'b1;
            end else if (is_done) begin
                if (done_cnt_q == ROW_LAST) begin
                    spike_map_d = pending_q;
                    pending_d   = '0;
                    ts_done_d   = 1'b1;
                    ts_count_d  = ts_count_q + 8'd1;
                    done_cnt_d  = '0;
                    state_d     = ST_REPLAY;
                    // A non-zero row counter means some adder fell short this timestep.
                    err_d       = |row_cnt_q;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end else if (!spk_ok) begin
                err_d = 1'b1;
            end else begin
                pending_d[spk_bit] = 1'b1;
            end
        end

        if (out_fire) begin
            if (rep_col_q == COL_LAST) begin
                rep_col_d = '0;
                if (rep_row_q == ROW_LAST) begin
                    rep_row_d = '0;
                    state_d   = ST_COLLECT;
                end else begin
                    rep_row_d = rep_row_q + 1'b1;
                end
            end else begin
                rep_col_d = rep_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            live_q      <= 1'b0;
            row_cnt_q   <= '0;
            done_cnt_q  <= '0;
            pending_q   <= '0;
            spike_map_q <= '0;
            ts_done_q   <= 1'b0;
            ts_count_q  <= '0;
            err_q       <= 1'b0;
            rep_row_q   <= '0;
            rep_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            row_cnt_q   <= row_cnt_d;
            done_cnt_q  <= done_cnt_d;
            pending_q   <= pending_d;
            spike_map_q <= spike_map_d;
            ts_done_q   <= ts_done_d;
            ts_count_q  <= ts_count_d;
            err_q       <= err_d;
            rep_row_q   <= rep_row_d;
            rep_col_q   <= rep_col_d;
        end
    end

    membrane_regfile #(
        .ROWS     (ROWS),
        .COLS     (ADDER_COUNT),
        .WIDTH_MP (WIDTH_MP),
        .RW       (RW),
        .AW       (AW)
    ) u_regfile (
        .clk       (clk),
        .clr_i     (!rst_n),
        .wr_en_i   (wr_en),
        .wr_row_i  (row_cnt_q[col]),
        .wr_col_i  (col),
        .wr_data_i (pkt.payload[WIDTH_MP-1:0]),
        .rd_row_i  (rep_row_q),
        .rd_col_i  (rep_col_q),
        .rd_data_o (rd_mp)
    );

    assign out_data  = {MEM_ADDR, ADDER_ADDR_BASE + 4'(rep_col_q), TYPE_MP, {PAD_W{1'b0}}, rd_mp};
    assign spike_map = spike_map_q;
    assign ts_done   = ts_done_q;
    assign ts_count  = ts_count_q;
    assign err_pkt   = err_q;

endmodule

// File: tb/tb_membrane_store.sv
// Directed bench for membrane_store: stimulus pushes expected replay packets into a
// queue that an independent monitor drains whenever a replay transfer happens.
module tb_membrane_store;

    localparam int R  = 5;
    localparam int AC = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, ts_done, err_pkt;
    logic [63:0] out_data;
    logic [24:0] spike_map;
    logic [7:0]  ts_count;

    int checks = 0;
    int failures = 0;
    int pops = 0;

    logic [63:0] exp_q[$];
    logic [12:0] mdl_mp [R][AC];
    int          mdl_row [AC];

    always #5 clk = ~clk;

    membrane_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .spike_map (spike_map),
        .ts_done   (ts_done),
        .ts_count  (ts_count),
        .err_pkt   (err_pkt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mp_pkt(input int a, input logic [12:0] v, input logic [40:0] junk);
        logic [3:0] s = 4'(6 + a);
        return {s, 4'h0, 2'b10, junk, v};
    endfunction

    function automatic logic [63:0] spk_pkt(input int src_a, input int r, input int a);
        logic [3:0] s = 4'(6 + src_a);
        return {s, 4'h0, 2'b11, 48'h0, 3'(r), 3'(a)};
    endfunction

    function automatic logic [63:0] done_pkt(input int src_a);
        logic [3:0] s = 4'(6 + src_a);
        return {s, 4'h0, 2'b11, 48'h0, 6'h0F};
    endfunction

    function automatic logic [63:0] exp_out(input int r, input int a);
        logic [3:0] d = 4'(6 + a);
        return {4'h0, d, 2'b10, 41'h0, mdl_mp[r][a]};
    endfunction

    task automatic clear_model();
        for (int r = 0; r < R; r++)
            for (int a = 0; a < AC; a++) mdl_mp[r][a] = '0;
        for (int a = 0; a < AC; a++) mdl_row[a] = 0;
    endtask

    task automatic push_replay();
        for (int r = 0; r < R; r++)
            for (int a = 0; a < AC; a++) exp_q.push_back(exp_out(r, a));
    endtask

    task automatic send(input logic [63:0] p, input logic exp_err, input string nm);
        int n = 0;
        in_data  = p;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s: in_ready stayed %0b, required 1", nm, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, " err_pkt"}, 64'(err_pkt), 64'(exp_err));
    endtask

    task automatic send_mp(input int a, input logic [12:0] v, input logic [40:0] junk);
        int r = mdl_row[a];
        mdl_mp[r][a] = v;
        mdl_row[a] = (r + 1) % R;
        send(mp_pkt(a, v, junk), 1'b0, "mp");
    endtask

    task automatic run_replay(input bit toggle, input int exp_cyc, input string nm);
        int  vc = 0;
        bit  seen = 0;
        bit  ended = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = (i % 2) != 0;
            if (i == 0) begin
                chk({nm, " first out_valid"}, 64'(out_valid), 64'd1);
                chk({nm, " ts_done pulse end"}, 64'(ts_done), 64'd0);
            end
            if (out_valid) begin
                seen = 1;
                vc++;
            end else if (seen) begin
                ended = 1;
                break;
            end
        end
        out_ready = 1'b1;
        if (!ended) begin
            checks++;
            failures++;
            $display("FAIL %s replay_timeout: out_valid cycles %0d, replay never ended", nm, vc);
        end
        chk({nm, " replay cycles"}, 64'(vc), 64'(exp_cyc));
        chk({nm, " packets left"}, 64'(exp_q.size()), 64'd0);
        chk({nm, " back to collect"}, 64'(in_ready), 64'd1);
    endtask

    // Scoreboard monitor: pops on every replay transfer, checks stall stability.
    initial begin
        logic [63:0] exp;
        logic [63:0] hold_data = '0;
        bit          hold_pend = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (hold_pend) begin
                    checks++;
                    if (out_data !== hold_data) begin
                        failures++;
                        $display("FAIL stall_stable: got %0h required %0h", out_data, hold_data);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL replay_extra: got %0h with nothing expected", out_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (out_data !== exp) begin
                            failures++;
                            $display("FAIL replay_pkt %0d: got %0h expected %0h", pops, out_data, exp);
                        end
                    end
                    pops++;
                    hold_pend = 0;
                end else begin
                    hold_pend = 1;
                    hold_data = out_data;
                end
            end else begin
                if (hold_pend && rst_n) begin
                    checks++;
                    failures++;
                    $display("FAIL stall_drop: out_valid got %0b required 1", out_valid);
                end
                hold_pend = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        clear_model();

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst spike_map", 64'(spike_map), 64'd0);
        chk("rst ts_count", 64'(ts_count), 64'd0);
        chk("rst ts_done", 64'(ts_done), 64'd0);
        chk("rst err_pkt", 64'(err_pkt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", 64'(in_ready), 64'd1);

        // Full timestep, spike before and after its membrane packet, duplicate spike
        send(spk_pkt(0, 4, 0), 1'b0, "spike r4a0");
        for (int r = 0; r < R; r++)
            for (int a = 0; a < AC; a++) send_mp(a, 13'(r * 10 + a), 41'h0);
        send(spk_pkt(1, 1, 2), 1'b0, "spike r1a2");
        send(spk_pkt(3, 1, 2), 1'b0, "spike dup");
        for (int k = 0; k < 4; k++) send(done_pkt(4), 1'b0, "done");
        chk("ts2 3rd pkt model", exp_out(0, 2), {4'h0, 4'h8, 2'b10, 41'h0, 13'd2});
        push_replay();
        send(done_pkt(4), 1'b0, "done last ts2");
        chk("ts2 ts_done", 64'(ts_done), 64'd1);
        chk("ts2 spike_map", 64'(spike_map), 64'h0100080);
        chk("ts2 ts_count", 64'(ts_count), 64'd1);
        chk("ts2 gap out_valid", 64'(out_valid), 64'd0);
        chk("ts2 replay in_ready", 64'(in_ready), 64'd0);
        run_replay(1'b0, 25, "ts2");

        // Backpressure, junk above the mp field
        for (int r = 0; r < R; r++)
            for (int a = 0; a < AC; a++) send_mp(a, 13'h1000 | 13'(r * 37 + a * 3), 41'h1ABCD);
        for (int k = 0; k < 4; k++) send(done_pkt(4), 1'b0, "done");
        push_replay();
        send(done_pkt(4), 1'b0, "done last ts3");
        chk("ts3 spike_map", 64'(spike_map), 64'd0);
        chk("ts3 ts_count", 64'(ts_count), 64'd2);
        run_replay(1'b1, 50, "ts3");

        // Malformed packets
        send({4'hF, 4'h0, 2'b10, 41'h0, 13'h0AA}, 1'b1, "bad src");
        send({4'h7, 4'h3, 2'b10, 41'h0, 13'h0BB}, 1'b1, "bad dst");
        send(spk_pkt(2, 5, 1), 1'b1, "bad spike row");
        send({4'h8, 4'h0, 2'b01, 41'h0, 13'h0CC}, 1'b1, "bad type");
        @(posedge clk);
        #1;
        chk("err pulse ends", 64'(err_pkt), 64'd0);
        chk("bad no ts_done", 64'(ts_done), 64'd0);

        // Incomplete timestep: adder 3 misses row 4
        for (int r = 0; r < R; r++)
            for (int a = 0; a < AC; a++)
                if (!(r == 4 && a == 3)) send_mp(a, 13'h1FFF - 13'(r * 5 + a), 41'h0);
        send(spk_pkt(0, 2, 3), 1'b0, "spike r2a3");
        for (int k = 0; k < 4; k++) send(done_pkt(4), 1'b0, "done");
        push_replay();
        send(done_pkt(4), 1'b1, "done last ts5");
        chk("ts5 ts_done", 64'(ts_done), 64'd1);
        chk("ts5 spike_map", 64'(spike_map), 64'h0002000);
        chk("ts5 ts_count", 64'(ts_count), 64'd3);
        run_replay(1'b0, 25, "ts5");

        // Reset in the middle of a replay
        for (int k = 0; k < 4; k++) send(done_pkt(4), 1'b0, "done");
        push_replay();
        send(done_pkt(4), 1'b1, "done last ts6");
        chk("ts6 ts_count", 64'(ts_count), 64'd4);
        start = pops;
        n = 0;
        while ((pops - start) < 6 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ts6 six transfers", 64'(pops - start), 64'd6);
        chk("ts6 7th valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        chk("midrst ts_count", 64'(ts_count), 64'd0);
        chk("midrst spike_map", 64'(spike_map), 64'd0);
        exp_q.delete();
        clear_model();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst collect", 64'(in_ready), 64'd1);
        chk("midrst idle out", 64'(out_valid), 64'd0);

        // Fresh timestep: only adder 2 writes, all other entries replay as zero
        for (int r = 0; r < R; r++) send_mp(2, 13'(200 + r), 41'h0);
        for (int k = 0; k < 4; k++) send(done_pkt(4), 1'b0, "done");
        push_replay();
        send(done_pkt(4), 1'b0, "done last ts7");
        chk("ts7 ts_count", 64'(ts_count), 64'd1);
        chk("ts7 spike_map", 64'(spike_map), 64'd0);
        run_replay(1'b0, 25, "ts7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
